// File: rtl/axi_rd_arbiter_n.sv
// axi_rd_arbiter_n: N-master AXI read-channel arbiter with address-region decode.
// A master is granted from AR request until its RLAST beat. The grant is
// fixed-priority (highest index) or round-robin. Accepted R beats are counted
// against the latched ARLEN, and a short or long burst raises a one-cycle len_err.

// One decode region: hit when the masked address equals the region base.
module axi_rd_arbiter_n_dec_cmp #(
  parameter int ADDR_W = 32
) (
  input  logic [ADDR_W-1:0] addr,
  input  logic [ADDR_W-1:0] base,
  input  logic [ADDR_W-1:0] mask,
  output logic              hit
);
  assign hit = ((addr & mask) == base);
endmodule

module axi_rd_arbiter_n #(
  parameter int NUM_M    = 2,
  parameter int NUM_S    = 6,
  parameter int ADDR_W   = 32,
  parameter int LEN_W    = 4,
  parameter int ARB_MODE = 0,
  parameter logic [NUM_S*ADDR_W-1:0] S_BASE = {32'h2000_0000, 32'h1001_0000, 32'h1000_0000,
                                               32'h0002_0000, 32'h0001_0000, 32'h0000_0000},
  parameter logic [NUM_S*ADDR_W-1:0] S_MASK = {32'hFF00_0000, {5{32'hFFFF_0000}}},
  localparam int IDX_W = $clog2(NUM_M),
  localparam int SEL_W = $clog2(NUM_S+1)
) (
  input  logic                    ACLK,
  input  logic                    ARESETn,
  input  logic [NUM_M-1:0]        ARVALID,
  input  logic [NUM_M-1:0]        ARREADY,
  input  logic [NUM_M*ADDR_W-1:0] ARADDR,
  input  logic [NUM_M*LEN_W-1:0]  ARLEN,
  input  logic [NUM_M-1:0]        RVALID,
  input  logic [NUM_M-1:0]        RREADY,
  input  logic [NUM_M-1:0]        RLAST,
  output logic [NUM_M-1:0]        gnt,
  output logic [IDX_W-1:0]        gnt_idx,
  output logic [SEL_W-1:0]        slv_sel,
  output logic                    slv_hit,
  output logic                    busy,
  output logic [LEN_W:0]          beat_cnt,
  output logic                    len_err
);

  typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

  typedef struct packed {
    logic [IDX_W-1:0]  idx;
    logic [ADDR_W-1:0] addr;
    logic [LEN_W-1:0]  len;
  } burst_t;

  localparam logic [NUM_S-1:0][ADDR_W-1:0] BASE_A = S_BASE;
  localparam logic [NUM_S-1:0][ADDR_W-1:0] MASK_A = S_MASK;

  logic [NUM_M-1:0][ADDR_W-1:0] araddr_m;
  logic [NUM_M-1:0][LEN_W-1:0]  arlen_m;

  state_t            state;
  burst_t            lat;
  logic [IDX_W-1:0]  rr_ptr;
  logic              err_seen;    // a length error was already reported for this burst

  logic              any_req;
  logic [IDX_W-1:0]  win_idx;
  logic              cur_vld;
  logic [IDX_W-1:0]  cur_idx;
  logic [ADDR_W-1:0] dec_addr;
  logic [NUM_S-1:0]  s_hit;
  logic [SEL_W-1:0]  dec_sel;
  logic              dec_hit;

  logic              ar_fire_win, ar_fire_lat, r_fire, r_last;
  logic [LEN_W+1:0]  beat_nxt, beat_exp;
  logic              beat_sat;

  assign araddr_m = ARADDR;
  assign arlen_m  = ARLEN;

  // A request seen while reset is held is not granted. Outputs stay at their idle values.
  assign any_req = (|ARVALID) & ~ARESETn;
  assign busy    = (state != IDLE);

  // Winner search: the highest index in fixed mode, or the search from rr_ptr downward with wrap in round-robin mode.
  always_comb begin
    int pos;
    pos     = 0;
    win_idx = '0;
    if (ARB_MODE == 0) begin
      for (int i = 0; i < NUM_M; i++)
        if (ARVALID[IDX_W'(i)]) win_idx = IDX_W'(i);
    end else begin
      for (int k = NUM_M-1; k >= 0; k--) begin
        pos = (int'(rr_ptr) - k + NUM_M) % NUM_M;
        if (ARVALID[IDX_W'(pos)]) win_idx = IDX_W'(pos);
      end
    end
  end

  assign ar_fire_win = ARVALID[win_idx] & ARREADY[win_idx];
  assign ar_fire_lat = ARVALID[lat.idx] & ARREADY[lat.idx];
  assign r_fire      = RVALID[lat.idx] & RREADY[lat.idx];
  assign r_last      = RLAST[lat.idx];

  assign beat_nxt = {1'b0, beat_cnt} + (LEN_W+2)'(1);
  assign beat_exp = {2'b00, lat.len} + (LEN_W+2)'(1);
  assign beat_sat = &beat_cnt;

  // In IDLE the live winner drives the outputs. After that the latched burst drives them.
  always_comb begin
    cur_vld  = busy | any_req;
    cur_idx  = busy ? lat.idx  : win_idx;
    dec_addr = busy ? lat.addr : araddr_m[win_idx];
  end

  genvar gs;
  generate
    for (gs = 0; gs < NUM_S; gs++) begin : g_reg
      axi_rd_arbiter_n_dec_cmp #(.ADDR_W(ADDR_W)) u_cmp (
        .addr (dec_addr),
        .base (BASE_A[gs]),
        .mask (MASK_A[gs]),
        .hit  (s_hit[gs])
      );
    end
  endgenerate

  // Region priority: the lowest matching index wins. A miss selects the default slave NUM_S.
  always_comb begin
    dec_sel = SEL_W'(NUM_S);
    dec_hit = 1'b0;
    for (int i = NUM_S-1; i >= 0; i--) begin
      if (s_hit[i]) begin
        dec_sel = SEL_W'(i);
        dec_hit = 1'b1;
      end
    end
  end

  // Grant and decode outputs are forced to zero when nothing is granted.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    slv_sel = '0;
    slv_hit = 1'b0;
    if (cur_vld) begin
      gnt[cur_idx] = 1'b1;
      gnt_idx      = cur_idx;
      slv_sel      = dec_sel;
      slv_hit      = dec_hit;
    end
  end

  // Arbitration FSM with burst latch, beat counter, length check and round-robin pointer.
  always_ff @(posedge ACLK or posedge ARESETn) begin
    if (ARESETn) begin
      state    <= IDLE;
      lat      <= '0;
      rr_ptr   <= IDX_W'(NUM_M-1);
      beat_cnt <= '0;
      len_err  <= 1'b0;
      err_seen <= 1'b0;
    end else begin
      len_err <= 1'b0;
      unique case (state)
        IDLE: begin
          if (any_req) begin
            lat.idx  <= win_idx;
            lat.addr <= araddr_m[win_idx];
            lat.len  <= arlen_m[win_idx];
            beat_cnt <= '0;
            err_seen <= 1'b0;
            state    <= ar_fire_win ? DATA : ADDR;
          end
        end
        ADDR: begin
          if (ar_fire_lat) state <= DATA;
        end
        DATA: begin
          if (r_fire) begin
            if (r_last) begin
              state    <= IDLE;
              beat_cnt <= '0;
              rr_ptr   <= (lat.idx == '0) ? IDX_W'(NUM_M-1) : lat.idx - 1'b1;
              if (!err_seen && (beat_nxt != beat_exp)) len_err <= 1'b1;
            end else begin
              if (!beat_sat) beat_cnt <= beat_cnt + 1'b1;
              // The expected final beat arrived without RLAST. Report it once and wait for RLAST.
              if (!err_seen && (beat_nxt == beat_exp)) begin
                len_err  <= 1'b1;
                err_seen <= 1'b1;
              end
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_rd_arbiter_n.sv
// Bench for axi_rd_arbiter_n. Instance A uses the 2-master fixed-priority arbiter.
// Instance B uses the 3-master round-robin arbiter. A directed table runs on A.
// A grant-order sequence and a mid-burst reset follow, then random traffic runs on both instances.
module tb_axi_rd_arbiter_n;

  logic ACLK = 1'b0;
  logic ARESETn;
  always #5 ACLK = ~ACLK;

  // instance A: NUM_M=2, fixed priority
  logic [1:0]  a_arvalid, a_arready, a_rvalid, a_rready, a_rlast;
  logic [63:0] a_araddr;
  logic [7:0]  a_arlen;
  logic [1:0]  a_gnt;
  logic [0:0]  a_gnt_idx;
  logic [2:0]  a_slv_sel;
  logic        a_slv_hit, a_busy, a_len_err;
  logic [4:0]  a_beat_cnt;

  // instance B: NUM_M=3, round-robin
  logic [2:0]  b_arvalid, b_arready, b_rvalid, b_rready, b_rlast;
  logic [95:0] b_araddr;
  logic [11:0] b_arlen;
  logic [2:0]  b_gnt;
  logic [1:0]  b_gnt_idx;
  logic [2:0]  b_slv_sel;
  logic        b_slv_hit, b_busy, b_len_err;
  logic [4:0]  b_beat_cnt;

  axi_rd_arbiter_n #(.NUM_M(2), .ARB_MODE(0)) u_a (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .ARVALID(a_arvalid), .ARREADY(a_arready), .ARADDR(a_araddr), .ARLEN(a_arlen),
    .RVALID(a_rvalid), .RREADY(a_rready), .RLAST(a_rlast),
    .gnt(a_gnt), .gnt_idx(a_gnt_idx), .slv_sel(a_slv_sel), .slv_hit(a_slv_hit),
    .busy(a_busy), .beat_cnt(a_beat_cnt), .len_err(a_len_err)
  );

  axi_rd_arbiter_n #(.NUM_M(3), .ARB_MODE(1)) u_b (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .ARVALID(b_arvalid), .ARREADY(b_arready), .ARADDR(b_araddr), .ARLEN(b_arlen),
    .RVALID(b_rvalid), .RREADY(b_rready), .RLAST(b_rlast),
    .gnt(b_gnt), .gnt_idx(b_gnt_idx), .slv_sel(b_slv_sel), .slv_hit(b_slv_hit),
    .busy(b_busy), .beat_cnt(b_beat_cnt), .len_err(b_len_err)
  );

  typedef struct packed {
    logic [2:0]       arv, arr, rv, rrd, rl;
    logic [2:0][31:0] addr;
    logic [2:0][3:0]  len;
  } stim_t;

  typedef struct {
    int gnt, gidx, sel, hit, busy, beat, err;
  } exp_t;

  typedef struct {
    stim_t s;
    exp_t  e;
  } vec_t;

  // Reference model: a burst record plus the round-robin pointer, kept as plain integers.
  typedef struct {
    int          act, addr_ok, flagged, pend, idx, len, beats, rr;
    logic [31:0] addr;
  } mdl_t;

  localparam logic [31:0] RB [6] = '{32'h0000_0000, 32'h0001_0000, 32'h0002_0000,
                                     32'h1000_0000, 32'h1001_0000, 32'h2000_0000};
  localparam logic [31:0] RM [6] = '{32'hFFFF_0000, 32'hFFFF_0000, 32'hFFFF_0000,
                                     32'hFFFF_0000, 32'hFFFF_0000, 32'hFF00_0000};
  localparam logic [31:0] ADDRS [8] = '{32'h0000_0010, 32'h0001_0004, 32'h0002_0040, 32'h1000_0100,
                                        32'h1001_0000, 32'h2012_3456, 32'h3000_0000, 32'h0003_0000};

  int   n_vec = 0;
  int   n_err = 0;
  vec_t tbl[$];
  int   rr_seq [5] = '{2, 1, 0, 2, 1};
  mdl_t ma, mb;
  stim_t sa, sb;

  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  task automatic chk(input string tag, input string f, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s %s: got %0d, want %0d", tag, f, act, exp);
    end
  endtask

  task automatic cmp_a(input string tag, input exp_t e);
    chk(tag, "gnt",      32'(a_gnt),      e.gnt);
    chk(tag, "gnt_idx",  32'(a_gnt_idx),  e.gidx);
    chk(tag, "slv_sel",  32'(a_slv_sel),  e.sel);
    chk(tag, "slv_hit",  32'(a_slv_hit),  e.hit);
    chk(tag, "busy",     32'(a_busy),     e.busy);
    chk(tag, "beat_cnt", 32'(a_beat_cnt), e.beat);
    chk(tag, "len_err",  32'(a_len_err),  e.err);
  endtask

  task automatic cmp_b(input string tag, input exp_t e);
    chk(tag, "gnt",      32'(b_gnt),      e.gnt);
    chk(tag, "gnt_idx",  32'(b_gnt_idx),  e.gidx);
    chk(tag, "slv_sel",  32'(b_slv_sel),  e.sel);
    chk(tag, "slv_hit",  32'(b_slv_hit),  e.hit);
    chk(tag, "busy",     32'(b_busy),     e.busy);
    chk(tag, "beat_cnt", 32'(b_beat_cnt), e.beat);
    chk(tag, "len_err",  32'(b_len_err),  e.err);
  endtask

  task automatic drive_a(input stim_t s);
    a_arvalid = s.arv[1:0]; a_arready = s.arr[1:0];
    a_rvalid  = s.rv[1:0];  a_rready  = s.rrd[1:0]; a_rlast = s.rl[1:0];
    a_araddr  = {s.addr[1], s.addr[0]};
    a_arlen   = {s.len[1], s.len[0]};
  endtask

  task automatic drive_b(input stim_t s);
    b_arvalid = s.arv; b_arready = s.arr;
    b_rvalid  = s.rv;  b_rready  = s.rrd; b_rlast = s.rl;
    b_araddr  = s.addr;
    b_arlen   = s.len;
  endtask

  // One table row for instance A: inputs, then the expected outputs for that cycle.
  task automatic add(input logic [1:0] arv, input logic [1:0] arr, input logic [31:0] a0,
                     input logic [31:0] a1, input logic [3:0] l0, input logic [3:0] l1,
                     input logic [1:0] rv, input logic [1:0] rrd, input logic [1:0] rl,
                     input int eg, input int egi, input int es, input int eh,
                     input int eb, input int ebt, input int ee);
    vec_t v;
    v.s = '0;
    v.s.arv = {1'b0, arv}; v.s.arr = {1'b0, arr};
    v.s.rv  = {1'b0, rv};  v.s.rrd = {1'b0, rrd}; v.s.rl = {1'b0, rl};
    v.s.addr[0] = a0; v.s.addr[1] = a1;
    v.s.len[0]  = l0; v.s.len[1]  = l1;
    v.e.gnt = eg; v.e.gidx = egi; v.e.sel = es; v.e.hit = eh;
    v.e.busy = eb; v.e.beat = ebt; v.e.err = ee;
    tbl.push_back(v);
  endtask

  function automatic int decode(input logic [31:0] a);
    for (int i = 0; i < 6; i++)
      if ((a & RM[i]) == RB[i]) return i;
    return 6;
  endfunction

  function automatic int winner(input mdl_t m, input stim_t s, input int nm, input int mode);
    int j;
    for (int k = 0; k < nm; k++) begin
      j = (mode == 0) ? nm - 1 - k : (m.rr - k + nm) % nm;
      if (s.arv[j]) return j;
    end
    return -1;
  endfunction

  function automatic mdl_t mreset(input int nm);
    mdl_t m;
    m.act = 0; m.addr_ok = 0; m.flagged = 0; m.pend = 0;
    m.idx = 0; m.len = 0; m.beats = 0; m.rr = nm - 1; m.addr = '0;
    return m;
  endfunction

  function automatic exp_t predict(input mdl_t m, input stim_t s, input int nm, input int mode);
    exp_t e;
    int   w;
    e.gnt = 0; e.gidx = 0; e.sel = 0; e.busy = m.act; e.beat = m.beats; e.err = m.pend;
    if (m.act != 0) begin
      e.gnt = 1 << m.idx; e.gidx = m.idx; e.sel = decode(m.addr);
    end else begin
      w = winner(m, s, nm, mode);
      if (w >= 0) begin
        e.gnt = 1 << w; e.gidx = w; e.sel = decode(s.addr[w]);
      end
    end
    e.hit = (e.gnt != 0 && e.sel < 6) ? 1 : 0;
    return e;
  endfunction

  function automatic mdl_t advance(input mdl_t m, input stim_t s, input int nm, input int mode);
    mdl_t n;
    int   w;
    n = m;
    n.pend = 0;
    if (m.act == 0) begin
      w = winner(m, s, nm, mode);
      if (w >= 0) begin
        n.act = 1; n.idx = w; n.addr = s.addr[w]; n.len = int'(s.len[w]);
        n.beats = 0; n.flagged = 0; n.addr_ok = (s.arv[w] && s.arr[w]) ? 1 : 0;
      end
    end else if (m.addr_ok == 0) begin
      if (s.arv[m.idx] && s.arr[m.idx]) n.addr_ok = 1;
    end else if (s.rv[m.idx] && s.rrd[m.idx]) begin
      if (s.rl[m.idx]) begin
        if (m.flagged == 0 && m.beats + 1 != m.len + 1) n.pend = 1;
        n.act = 0; n.beats = 0; n.rr = (m.idx + nm - 1) % nm;
      end else begin
        n.beats = (m.beats < 31) ? m.beats + 1 : 31;
        if (m.flagged == 0 && n.beats == m.len + 1) begin
          n.pend = 1; n.flagged = 1;
        end
      end
    end
    return n;
  endfunction

  function automatic stim_t rnd_stim(input int nm);
    stim_t s;
    s = '0;
    for (int i = 0; i < nm; i++) begin
      s.arv[i]  = ($urandom_range(0, 1) == 1);
      s.arr[i]  = ($urandom_range(0, 2) != 0);
      s.rv[i]   = ($urandom_range(0, 3) != 0);
      s.rrd[i]  = ($urandom_range(0, 3) != 0);
      s.rl[i]   = ($urandom_range(0, 2) == 0);
      s.addr[i] = ADDRS[$urandom_range(0, 7)];
      s.len[i]  = 4'($urandom_range(0, 3));
    end
    return s;
  endfunction

  // Stop the run if it does not finish within the cycle budget.
  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, want finish before 200000");
    $fatal(1);
  end

  initial begin
    exp_t  ez;
    stim_t s;
    ez.gnt = 0; ez.gidx = 0; ez.sel = 0; ez.hit = 0; ez.busy = 0; ez.beat = 0; ez.err = 0;

    //   arv   arr   addr0         addr1         l0 l1 rv    rrd   rl      gnt gi sel hit busy beat err
    // single burst: M0, slave 2, ARLEN=3, AR accepted at once
    add(2'b01,2'b01,32'h0002_0040,32'h0,        3, 0, 2'b00,2'b00,2'b00,  1, 0, 2, 1, 0, 0, 0);
    add(2'b00,2'b00,32'h0,        32'h0,        0, 0, 2'b01,2'b01,2'b00,  1, 0, 2, 1, 1, 0, 0);
    add(2'b00,2'b00,32'h0,        32'h0,        0, 0, 2'b01,2'b01,2'b00,  1, 0, 2, 1, 1, 1, 0);
    add(2'b00,2'b00,32'h0,        32'h0,        0, 0, 2'b01,2'b01,2'b00,  1, 0, 2, 1, 1, 2, 0);
    add(2'b00,2'b00,32'h0,        32'h0,        0, 0, 2'b01,2'b01,2'b01,  1, 0, 2, 1, 1, 3, 0);
    add(2'b00,2'b00,32'h0,        32'h0,        0, 0, 2'b00,2'b00,2'b00,  0, 0, 0, 0, 0, 0, 0);
    // fixed priority: M1 wins, waits in ADDR, then M0; M1 cannot preempt
    add(2'b11,2'b00,32'h0,        32'h2000_0100,0, 0, 2'b00,2'b00,2'b00,  2, 1, 5, 1, 0, 0, 0);
    add(2'b11,2'b10,32'h0,        32'h2000_0100,0, 0, 2'b00,2'b00,2'b00,  2, 1, 5, 1, 1, 0, 0);
    add(2'b01,2'b00,32'h0,        32'h0,        0, 0, 2'b10,2'b10,2'b10,  2, 1, 5, 1, 1, 0, 0);
    add(2'b01,2'b01,32'h0,        32'h0,        1, 0, 2'b00,2'b00,2'b00,  1, 0, 0, 1, 0, 0, 0);
    add(2'b10,2'b10,32'h0,        32'h2000_0000,0, 0, 2'b11,2'b11,2'b10,  1, 0, 0, 1, 1, 0, 0);
    add(2'b10,2'b10,32'h0,        32'h2000_0000,0, 0, 2'b01,2'b01,2'b01,  1, 0, 0, 1, 1, 1, 0);
    add(2'b00,2'b00,32'h0,        32'h0,        0, 0, 2'b00,2'b00,2'b00,  0, 0, 0, 0, 0, 0, 0);
    // decode miss: default slave 6, grant held until RLAST
    add(2'b01,2'b01,32'h3000_0000,32'h0,        0, 0, 2'b00,2'b00,2'b00,  1, 0, 6, 0, 0, 0, 0);
    add(2'b00,2'b00,32'h0,        32'h0,        0, 0, 2'b01,2'b00,2'b00,  1, 0, 6, 0, 1, 0, 0);
    add(2'b00,2'b00,32'h0,        32'h0,        0, 0, 2'b01,2'b01,2'b01,  1, 0, 6, 0, 1, 0, 0);
    add(2'b00,2'b00,32'h0,        32'h0,        0, 0, 2'b00,2'b00,2'b00,  0, 0, 0, 0, 0, 0, 0);
    // short burst: ARLEN=1, RLAST on beat 1
    add(2'b01,2'b01,32'h0001_0000,32'h0,        1, 0, 2'b00,2'b00,2'b00,  1, 0, 1, 1, 0, 0, 0);
    add(2'b00,2'b00,32'h0,        32'h0,        0, 0, 2'b01,2'b01,2'b01,  1, 0, 1, 1, 1, 0, 0);
    add(2'b00,2'b00,32'h0,        32'h0,        0, 0, 2'b00,2'b00,2'b00,  0, 0, 0, 0, 0, 0, 1);
    add(2'b00,2'b00,32'h0,        32'h0,        0, 0, 2'b00,2'b00,2'b00,  0, 0, 0, 0, 0, 0, 0);
    // long burst: ARLEN=0, no RLAST on beat 1, one pulse, leaves on later RLAST
    add(2'b01,2'b01,32'h1001_0010,32'h0,        0, 0, 2'b00,2'b00,2'b00,  1, 0, 4, 1, 0, 0, 0);
    add(2'b00,2'b00,32'h0,        32'h0,        0, 0, 2'b01,2'b01,2'b00,  1, 0, 4, 1, 1, 0, 0);
    add(2'b00,2'b00,32'h0,        32'h0,        0, 0, 2'b01,2'b01,2'b00,  1, 0, 4, 1, 1, 1, 1);
    add(2'b00,2'b00,32'h0,        32'h0,        0, 0, 2'b00,2'b00,2'b00,  1, 0, 4, 1, 1, 2, 0);
    add(2'b00,2'b00,32'h0,        32'h0,        0, 0, 2'b01,2'b01,2'b01,  1, 0, 4, 1, 1, 2, 0);
    add(2'b00,2'b00,32'h0,        32'h0,        0, 0, 2'b00,2'b00,2'b00,  0, 0, 0, 0, 0, 0, 0);

    // reset state
    ARESETn = 1'b1;
    drive_a('0);
    drive_b('0);
    tick();
    cmp_a("reset_a", ez);
    cmp_b("reset_b", ez);
    ARESETn = 1'b0;

    // directed table on instance A
    foreach (tbl[i]) begin
      drive_a(tbl[i].s);
      #2;
      cmp_a($sformatf("vec%0d", i), tbl[i].e);
      tick();
    end
    drive_a('0);

    // round-robin order on instance B: all masters request, 1-beat bursts
    s = '0;
    s.arv = 3'b111; s.arr = 3'b111; s.rv = 3'b111; s.rrd = 3'b111; s.rl = 3'b111;
    drive_b(s);
    for (int n = 0; n < 5; n++) begin
      #2;
      chk($sformatf("rr%0d_req", n), "gnt_idx", 32'(b_gnt_idx), rr_seq[n]);
      chk($sformatf("rr%0d_req", n), "gnt",     32'(b_gnt),     1 << rr_seq[n]);
      chk($sformatf("rr%0d_req", n), "busy",    32'(b_busy),    0);
      tick();
      #2;
      chk($sformatf("rr%0d_dat", n), "gnt_idx", 32'(b_gnt_idx), rr_seq[n]);
      chk($sformatf("rr%0d_dat", n), "busy",    32'(b_busy),    1);
      tick();
    end

    // asynchronous reset between edges: A in DATA with 2 beats, B in ADDR.
    // B's pointer has moved to 0 by now.
    s = '0;
    s.arv = 3'b001; s.arr = 3'b001; s.addr[0] = 32'h0002_0000; s.len[0] = 4'd3;
    drive_a(s);
    s = '0;
    s.arv = 3'b111;
    drive_b(s);
    tick();
    s = '0;
    s.rv = 3'b001; s.rrd = 3'b001;
    drive_a(s);
    #2;
    chk("rst_pre", "a_busy",    32'(a_busy),    1);
    chk("rst_pre", "b_busy",    32'(b_busy),    1);
    chk("rst_pre", "b_gnt_idx", 32'(b_gnt_idx), 0);
    tick();
    tick();
    #3;
    chk("rst_pre", "a_beat_cnt", 32'(a_beat_cnt), 2);
    ARESETn = 1'b1;
    #1;
    cmp_a("rst_mid_a", ez);
    chk("rst_mid_b", "gnt",  32'(b_gnt),  0);
    chk("rst_mid_b", "busy", 32'(b_busy), 0);
    @(posedge ACLK);
    #3;
    ARESETn = 1'b0;
    drive_a('0);
    #1;
    chk("rst_rel_b", "gnt_idx", 32'(b_gnt_idx), 2);
    chk("rst_rel_b", "gnt",     32'(b_gnt),     4);
    tick();
    #2;
    chk("rst_rel_a", "len_err", 32'(a_len_err), 0);
    chk("rst_rel_a", "busy",    32'(a_busy),    0);
    chk("rst_rel_b", "busy",    32'(b_busy),    1);

    // random traffic against the reference model on both instances
    drive_b('0);
    ARESETn = 1'b1;
    tick();
    ARESETn = 1'b0;
    ma = mreset(2);
    mb = mreset(3);
    for (int c = 0; c < 600; c++) begin
      sa = rnd_stim(2);
      sb = rnd_stim(3);
      drive_a(sa);
      drive_b(sb);
      #2;
      cmp_a($sformatf("rnd_a%0d", c), predict(ma, sa, 2, 0));
      cmp_b($sformatf("rnd_b%0d", c), predict(mb, sb, 3, 1));
      tick();
      ma = advance(ma, sa, 2, 0);
      mb = advance(mb, sb, 3, 1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
